// File: rtl/alu_issue.sv
// alu_issue: decode-to-ALU issue block. Takes one decoded instruction at a
// time, drives registered operands and selection to a combinational ALU,
// captures the result and returns it over a backpressured response handshake.
module alu_issue #(
    parameter bit EN_BRANCH = 1'b1,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [31:0]        rs_val,
    input  logic [31:0]        rt_val,
    input  logic [15:0]        imm,
    output logic [31:0]        alu_op1,
    output logic [31:0]        alu_op2,
    output logic [5:0]         alu_sel,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic               out_branch_taken,
    output logic               out_illegal,
    output logic [COUNT_W-1:0] op_count
);

    localparam logic [5:0] SEL_ADD = 6'b100000;
    localparam logic [5:0] SEL_SUB = 6'b100010;
    localparam logic [5:0] SEL_AND = 6'b100100;
    localparam logic [5:0] SEL_OR  = 6'b100101;
    localparam logic [5:0] SEL_NOR = 6'b100111;
    localparam logic [5:0] SEL_SLT = 6'b101010;
    localparam logic [5:0] SEL_XOR = 6'b100110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [COUNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [5:0]  dec_sel;
    logic [31:0] dec_op2;
    logic        dec_beq;
    logic        dec_bne;
    logic        dec_ill;

    logic        is_beq;
    logic        is_bne;
    logic        illegal_q;

    logic        accept;
    logic        retire;

    // Immediate extension: signed view widens with the sign bit replicated.
    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        logic signed [31:0] w;
        w = v;
        return w;
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == RESP);
    assign accept    = in_ready && in_valid;
    assign retire    = out_valid && out_ready;

    // Decode opcode/funct into ALU selection, second operand and flags.
    always_comb begin
        dec_sel = SEL_ADD;
        dec_op2 = rt_val;
        dec_beq = 1'b0;
        dec_bne = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    SEL_ADD, SEL_SUB, SEL_AND, SEL_OR,
                    SEL_NOR, SEL_SLT, SEL_XOR: dec_sel = funct;
                    default:                   dec_ill = 1'b1;
                endcase
            end
            OP_ADDI: dec_op2 = sext16(imm);
            OP_SLTI: begin
                dec_sel = SEL_SLT;
                dec_op2 = sext16(imm);
            end
            OP_ANDI: begin
                dec_sel = SEL_AND;
                dec_op2 = zext16(imm);
            end
            OP_ORI: begin
                dec_sel = SEL_OR;
                dec_op2 = zext16(imm);
            end
            OP_XORI: begin
                dec_sel = SEL_XOR;
                dec_op2 = zext16(imm);
            end
            OP_BEQ: begin
                if (EN_BRANCH) begin
                    dec_sel = SEL_SUB;
                    dec_beq = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OP_BNE: begin
                if (EN_BRANCH) begin
                    dec_sel = SEL_SUB;
                    dec_bne = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: EXEC is a single cycle, RESP waits for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue stage: latch operands and decode flags on accept; held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1   <= '0;
            alu_op2   <= '0;
            alu_sel   <= '0;
            is_beq    <= 1'b0;
            is_bne    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            alu_op1   <= rs_val;
            alu_op2   <= dec_op2;
            alu_sel   <= dec_sel;
            is_beq    <= dec_beq;
            is_bne    <= dec_bne;
            illegal_q <= dec_ill;
        end
    end

    // Response stage: capture the ALU return at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result       <= '0;
            out_branch_taken <= 1'b0;
            out_illegal      <= 1'b0;
        end else if (state == EXEC) begin
            out_result       <= alu_result;
            out_branch_taken <= is_beq ? alu_zero : (is_bne ? ~alu_zero : 1'b0);
            out_illegal      <= illegal_q;
        end
    end

    // Retired-operation counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      op_count <= '0;
        else if (retire) op_count <= op_count + CNT_ONE;
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: two alu_issue instances (branches enabled / 16-bit counter,
// and branches disabled / 2-bit counter) driven in lockstep from the same
// stimulus, each checked against a behavioural model of the issue block.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm;
    logic        out_ready;

    logic        a_in_ready, b_in_ready;
    logic [31:0] a_op1, a_op2, b_op1, b_op2;
    logic [5:0]  a_sel, b_sel;
    logic [31:0] a_res, b_res;
    logic        a_zero, b_zero;
    logic        a_out_valid, b_out_valid;
    logic [31:0] a_out_result, b_out_result;
    logic        a_taken, b_taken;
    logic        a_ill, b_ill;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int nvec = 0;
    int nerr = 0;
    int retired = 0;

    typedef struct {
        logic [5:0]  sel;
        logic [31:0] op2;
        logic        ill;
        logic        taken;
        logic [31:0] res;
    } exp_t;

    // Environment ALU; slt is an unsigned compare.
    function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                          input logic [5:0] s);
        case (s)
            6'b100000: return x + y;
            6'b100010: return x - y;
            6'b100100: return x & y;
            6'b100101: return x | y;
            6'b100111: return ~(x | y);
            6'b101010: return (x < y) ? 32'd1 : 32'd0;
            6'b100110: return x ^ y;
            default:   return 32'd0;
        endcase
    endfunction

    assign a_res  = alu_f(a_op1, a_op2, a_sel);
    assign a_zero = (a_res == 32'd0);
    assign b_res  = alu_f(b_op1, b_op2, b_sel);
    assign b_zero = (b_res == 32'd0);

    alu_issue #(.EN_BRANCH(1'b1), .COUNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .alu_op1(a_op1), .alu_op2(a_op2), .alu_sel(a_sel),
        .alu_result(a_res), .alu_zero(a_zero),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_out_result),
        .out_branch_taken(a_taken), .out_illegal(a_ill), .op_count(a_cnt)
    );

    alu_issue #(.EN_BRANCH(1'b0), .COUNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .opcode(opcode), .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .alu_op1(b_op1), .alu_op2(b_op2), .alu_sel(b_sel),
        .alu_result(b_res), .alu_zero(b_zero),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_result(b_out_result),
        .out_branch_taken(b_taken), .out_illegal(b_ill), .op_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: what the issue block should present for one instruction.
    function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] im, input bit en_br);
        exp_t e;
        bit beq, bne;
        beq = 0;
        bne = 0;
        e.sel = 6'b100000;
        e.op2 = rt;
        e.ill = 1'b0;
        if (opc == 6'd0) begin
            if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b100111, 6'b101010, 6'b100110}) e.sel = fn;
            else e.ill = 1'b1;
        end else if (opc == 6'b001000) begin
            e.op2 = {{16{im[15]}}, im};
        end else if (opc == 6'b001010) begin
            e.sel = 6'b101010; e.op2 = {{16{im[15]}}, im};
        end else if (opc == 6'b001100) begin
            e.sel = 6'b100100; e.op2 = {16'h0, im};
        end else if (opc == 6'b001101) begin
            e.sel = 6'b100101; e.op2 = {16'h0, im};
        end else if (opc == 6'b001110) begin
            e.sel = 6'b100110; e.op2 = {16'h0, im};
        end else if ((opc == 6'b000100 || opc == 6'b000101) && en_br) begin
            e.sel = 6'b100010;
            beq = (opc == 6'b000100);
            bne = (opc == 6'b000101);
        end else begin
            e.ill = 1'b1;
        end
        e.res   = alu_f(rs, e.op2, e.sel);
        e.taken = beq ? (rs == rt) : (bne ? (rs != rt) : 1'b0);
        return e;
    endfunction

    task automatic scramble_inputs();
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
        imm    = 16'($urandom);
    endtask

    // One full transaction; inputs driven and outputs sampled 1 time unit after posedge.
    task automatic do_txn(input logic [5:0] opc, input logic [5:0] fn,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [15:0] im, input int stall);
        exp_t ea, eb;
        ea = model(opc, fn, rs, rt, im, 1'b1);
        eb = model(opc, fn, rs, rt, im, 1'b0);
        check("idle_in_ready_a", 32'(a_in_ready), 32'd1);
        check("idle_in_ready_b", 32'(b_in_ready), 32'd1);
        in_valid = 1'b1;
        opcode = opc; funct = fn; rs_val = rs; rt_val = rt; imm = im;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        check("exec_sel_a", 32'(a_sel), 32'(ea.sel));
        check("exec_op1_a", a_op1, rs);
        check("exec_op2_a", a_op2, ea.op2);
        check("exec_sel_b", 32'(b_sel), 32'(eb.sel));
        check("exec_op2_b", b_op2, eb.op2);
        check("exec_in_ready_a", 32'(a_in_ready), 32'd0);
        check("exec_out_valid_a", 32'(a_out_valid), 32'd0);
        @(posedge clk); #1;
        check("resp_valid_a", 32'(a_out_valid), 32'd1);
        check("resp_result_a", a_out_result, ea.res);
        check("resp_taken_a", 32'(a_taken), 32'(ea.taken));
        check("resp_illegal_a", 32'(a_ill), 32'(ea.ill));
        check("resp_valid_b", 32'(b_out_valid), 32'd1);
        check("resp_result_b", b_out_result, eb.res);
        check("resp_taken_b", 32'(b_taken), 32'(eb.taken));
        check("resp_illegal_b", 32'(b_ill), 32'(eb.ill));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            scramble_inputs();
            @(posedge clk); #1;
            check("stall_valid_a", 32'(a_out_valid), 32'd1);
            check("stall_in_ready_a", 32'(a_in_ready), 32'd0);
            check("stall_result_a", a_out_result, ea.res);
            check("stall_taken_a", 32'(a_taken), 32'(ea.taken));
            check("stall_illegal_a", 32'(a_ill), 32'(ea.ill));
            check("stall_sel_a", 32'(a_sel), 32'(ea.sel));
            check("stall_result_b", b_out_result, eb.res);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        retired++;
        check("post_valid_a", 32'(a_out_valid), 32'd0);
        check("post_in_ready_a", 32'(a_in_ready), 32'd1);
        check("post_in_ready_b", 32'(b_in_ready), 32'd1);
        check("post_result_hold_a", a_out_result, ea.res);
        check("post_op2_hold_a", a_op2, ea.op2);
        check("op_count_a", 32'(a_cnt), 32'(retired % 65536));
        check("op_count_b", 32'(b_cnt), 32'(retired % 4));
    endtask

    initial begin
        logic [5:0]  opcs [9];
        logic [5:0]  fns  [8];
        logic [5:0]  o, f;
        logic [31:0] r1, r2;

        opcs = '{6'b000000, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
                 6'b001110, 6'b000100, 6'b000101, 6'b111111};
        fns  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                 6'b100111, 6'b101010, 6'b100110, 6'b000000};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        opcode = '0; funct = '0; rs_val = '0; rt_val = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_a", 32'(a_in_ready), 32'd1);
        check("rst_out_valid_a", 32'(a_out_valid), 32'd0);
        check("rst_sel_a", 32'(a_sel), 32'd0);
        check("rst_op1_a", a_op1, 32'd0);
        check("rst_result_a", a_out_result, 32'd0);
        check("rst_count_a", 32'(a_cnt), 32'd0);
        check("rst_count_b", 32'(b_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        do_txn(6'b000000, 6'b100000, 32'hFFFF_FFFF, 32'd1, 16'h0000, 0);
        do_txn(6'b001000, 6'b000000, 32'd10, 32'd0, 16'hFFFE, 0);
        do_txn(6'b001101, 6'b000000, 32'd0, 32'd0, 16'h8001, 0);
        do_txn(6'b000100, 6'b000000, 32'h1234, 32'h1234, 16'h0000, 0);
        do_txn(6'b000101, 6'b000000, 32'h1234, 32'h1234, 16'h0000, 0);
        do_txn(6'b000101, 6'b000000, 32'd5, 32'd3, 16'h0000, 0);
        do_txn(6'b111111, 6'b000000, 32'd7, 32'd9, 16'h0000, 0);
        do_txn(6'b000000, 6'b000000, 32'd7, 32'd9, 16'h0000, 0);
        do_txn(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 16'h0000, 5);
        do_txn(6'b001010, 6'b000000, 32'd1, 32'd0, 16'hFFFF, 1);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            o  = opcs[$urandom_range(0, 8)];
            if (o == 6'b111111) o = 6'($urandom);
            f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            r1 = $urandom;
            r2 = ($urandom_range(0, 2) == 0) ? r1 : $urandom;
            do_txn(o, f, r1, r2, 16'($urandom), $urandom_range(0, 3));
        end

        // Reset during EXEC drops the operation
        in_valid = 1'b1;
        opcode = 6'b000000; funct = 6'b100000; rs_val = 32'd3; rt_val = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid_a", 32'(a_out_valid), 32'd0);
        check("midrst_in_ready_a", 32'(a_in_ready), 32'd1);
        check("midrst_count_a", 32'(a_cnt), 32'd0);
        check("midrst_count_b", 32'(b_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        retired = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_no_resp_a", 32'(a_out_valid), 32'd0);
            check("midrst_idle_a", 32'(a_in_ready), 32'd1);
        end
        do_txn(6'b001100, 6'b000000, 32'hF0F0_F0F0, 32'd0, 16'hFF00, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
